ks_prefix_pipe: RTL and testbench

- Pipelined Kogge-Stone prefix network and sum stage of the 32-bit adder in the execute unit.
- Sits directly downstream of the bitwise propagate/generate stage and consumes its per-bit p/g vectors and carry-in.
- Produces sum, carry-out and optional flags behind a valid/ready handshake, so the adder can be registered without stalling the producer.

---
 rtl/ks_prefix_pipe.sv | 186 ++++++++++++++++++
 tb/tb_ks_prefix_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ks_prefix_pipe.sv
// ks_prefix_pipe: pipelined Kogge-Stone prefix network and sum stage of the 32-bit adder.
// Consumes per-bit propagate/generate and carry-in. Produces sum and carry-out behind a
// valid/ready handshake.
// Stage A always registers levels d=1,2,4. Stage B computes levels d=8,16 and the sum.
// Stage B is registered when PIPE_B=1 and combinational when PIPE_B=0.
// RESET_DATA=1 gives the data registers an async reset; RESET_DATA=0 resets only the valid bits.
// Optional feature macro: KS_FLAG_EN adds the o_overflow and o_zero flags.
module ks_prefix_pipe #(
   parameter int PIPE_B     = 1,
   parameter int RESET_DATA = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_pk_1,
   input  logic [31:0] i_gk_1,
   input  logic        i_c0_1,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_sum,
   output logic        o_cout
`ifdef KS_FLAG_EN
   ,
   output logic        o_overflow,
   output logic        o_zero
`endif
);

   localparam int AW = 89;
`ifdef KS_FLAG_EN
   localparam int OW = 35;
`else
   localparam int OW = 33;
`endif

   logic [31:0] g0f, g1, p1, g2, p2, g4;
   logic [31:8] p4;
   logic [AW-1:0] a_d, a_q;
   logic        va, ready_a, ready_b, load_a;
   logic        ca;
   logic [31:0] pr, ga, g8, gg;
   logic [31:8] pa;
   logic [31:16] p8;
   logic [31:0] sum_b;
   logic        cout_b;
   logic [OW-1:0] out_d, out_q;

   // Carry-in folded into bit 0 so the network needs no separate carry path
   assign g0f = {i_gk_1[31:1], i_gk_1[0] | (i_pk_1[0] & i_c0_1)};

   for (genvar i = 0; i < 32; i++) begin : g_l1
      if (i < 1) begin : g_pass
         assign g1[i] = g0f[i];
         assign p1[i] = i_pk_1[i];
      end else begin : g_op
         assign g1[i] = g0f[i] | (i_pk_1[i] & g0f[i-1]);
         assign p1[i] = i_pk_1[i] & i_pk_1[i-1];
      end
   end

   for (genvar i = 0; i < 32; i++) begin : g_l2
      if (i < 2) begin : g_pass
         assign g2[i] = g1[i];
         assign p2[i] = p1[i];
      end else begin : g_op
         assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
         assign p2[i] = p1[i] & p1[i-2];
      end
   end

   for (genvar i = 0; i < 32; i++) begin : g_l4
      if (i < 4) begin : g_pass
         assign g4[i] = g2[i];
      end else begin : g_op
         assign g4[i] = g2[i] | (p2[i] & g2[i-4]);
      end
   end

   // Group propagate below bit 8 is never consumed by the later levels, so it is not kept
   for (genvar i = 8; i < 32; i++) begin : g_p4
      assign p4[i] = p2[i] & p2[i-4];
   end

   assign load_a  = i_valid & ready_a & ~i_flush;
   assign ready_a = ~va | ready_b;
   assign o_ready = ready_a;
   assign a_d     = {i_c0_1, i_pk_1, p4, g4};

   // Stage A valid: flush wins over a new accept
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)             va <= 1'b0;
      else if (i_flush)      va <= 1'b0;
      else if (ready_a)      va <= i_valid;
   end

   if (RESET_DATA != 0) begin : g_a_rst
      // Stage A data, cleared by reset
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst)       a_q <= '0;
         else if (load_a) a_q <= a_d;
      end
   end else begin : g_a_nrst
      // Stage A data, no reset
      always_ff @(posedge i_clk) begin
         if (load_a) a_q <= a_d;
      end
   end

   assign ca = a_q[88];
   assign pr = a_q[87:56];
   assign pa = a_q[55:32];
   assign ga = a_q[31:0];

   for (genvar i = 0; i < 32; i++) begin : g_l8
      if (i < 8) begin : g_pass
         assign g8[i] = ga[i];
      end else begin : g_op
         assign g8[i] = ga[i] | (pa[i] & ga[i-8]);
      end
   end

   for (genvar i = 16; i < 32; i++) begin : g_p8
      assign p8[i] = pa[i] & pa[i-8];
   end

   for (genvar i = 0; i < 32; i++) begin : g_l16
      if (i < 16) begin : g_pass
         assign gg[i] = g8[i];
      end else begin : g_op
         assign gg[i] = g8[i] | (p8[i] & g8[i-16]);
      end
   end

   assign sum_b  = pr ^ {gg[30:0], ca};
   assign cout_b = gg[31];

`ifdef KS_FLAG_EN
   assign out_d = {(sum_b == 32'h0), gg[30] ^ gg[31], cout_b, sum_b};
`else
   assign out_d = {cout_b, sum_b};
`endif

   if (PIPE_B != 0) begin : g_pipe_b
      logic vb;
      logic load_b;

      assign ready_b = ~vb | i_ready;
      assign load_b  = va & ready_b;
      assign o_valid = vb;

      // Stage B valid: moves forward when the output slot frees up
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst)        vb <= 1'b0;
         else if (i_flush) vb <= 1'b0;
         else if (ready_b) vb <= va;
      end

      if (RESET_DATA != 0) begin : g_b_rst
         // Output register, cleared by reset
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)       out_q <= '0;
            else if (load_b) out_q <= out_d;
         end
      end else begin : g_b_nrst
         // Output register, no reset
         always_ff @(posedge i_clk) begin
            if (load_b) out_q <= out_d;
         end
      end
   end else begin : g_comb_b
      assign ready_b = i_ready;
      assign o_valid = va;
      assign out_q   = out_d;
   end

   assign o_sum  = out_q[31:0];
   assign o_cout = out_q[32];
`ifdef KS_FLAG_EN
   assign o_overflow = out_q[33];
   // Gated by valid: cleared stage A data would otherwise read as a zero sum
   assign o_zero     = out_q[34] & o_valid;
`endif

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// Directed bench for ks_prefix_pipe.
// Runs a PIPE_B=1 instance and a PIPE_B=0 instance side by side.
module tb_ks_prefix_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, valid, ready, c0;
   logic [31:0] pk, gk;
   logic        o_ready, o_valid, o_cout;
   logic [31:0] o_sum;
   logic        r0_ready, v0_valid, c0_cout;
   logic [31:0] s0_sum;
`ifdef KS_FLAG_EN
   logic        o_ovf, o_zero, f0_ovf, f0_zero;
`endif

   int total = 0;
   int bad   = 0;

   ks_prefix_pipe #(.PIPE_B(1), .RESET_DATA(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
      .i_pk_1(pk), .i_gk_1(gk), .i_c0_1(c0), .o_valid(o_valid), .i_ready(ready),
      .o_sum(o_sum), .o_cout(o_cout)
`ifdef KS_FLAG_EN
      , .o_overflow(o_ovf), .o_zero(o_zero)
`endif
   );

   ks_prefix_pipe #(.PIPE_B(0), .RESET_DATA(1)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(r0_ready),
      .i_pk_1(pk), .i_gk_1(gk), .i_c0_1(c0), .o_valid(v0_valid), .i_ready(ready),
      .o_sum(s0_sum), .o_cout(c0_cout)
`ifdef KS_FLAG_EN
      , .o_overflow(f0_ovf), .o_zero(f0_zero)
`endif
   );

   // p, g, c0 -> sum, cout, zero, overflow
   logic [31:0] vp [0:6] = '{32'hFFFFFFFE, 32'h7FFFFFFE, 32'h0, 32'hFFFFFFFF,
                             32'h1D3B5977, 32'h0000FFFE, 32'h0};
   logic [31:0] vg [0:6] = '{32'h1, 32'h1, 32'h0, 32'h0,
                             32'h02040608, 32'h1, 32'h80000000};
   logic        vc [0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [31:0] vs [0:6] = '{32'h0, 32'h80000000, 32'h1, 32'h0,
                             32'h21436587, 32'h00010000, 32'h0};
   logic        vco[0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic        vz [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic        vo [0:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx_in, idx_out, seen, seen0;
      rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1;
      pk = '0; gk = '0; c0 = 1'b0;
      #2;
      check_val("rst_valid", o_valid, 1'b0);
      check_val("rst_sum", o_sum, 32'h0);
      check_val("rst_cout", o_cout, 1'b0);
      check_val("rst_valid0", v0_valid, 1'b0);
      #10 rst = 1'b0;
      step();
      check_val("ready_after_rst", o_ready, 1'b1);

      // single vectors: latency 2 (PIPE_B=1) and 1 (PIPE_B=0), no duplicate
      for (int k = 0; k < 7; k++) begin
         pk = vp[k]; gk = vg[k]; c0 = vc[k]; valid = 1'b1;
         step();
         valid = 1'b0;
         check_val($sformatf("early_valid_%0d", k), o_valid, 1'b0);
         check_val($sformatf("p0_valid_%0d", k), v0_valid, 1'b1);
         check_val($sformatf("p0_sum_%0d", k), s0_sum, vs[k]);
         check_val($sformatf("p0_cout_%0d", k), c0_cout, vco[k]);
         step();
         check_val($sformatf("valid_%0d", k), o_valid, 1'b1);
         check_val($sformatf("sum_%0d", k), o_sum, vs[k]);
         check_val($sformatf("cout_%0d", k), o_cout, vco[k]);
`ifdef KS_FLAG_EN
         check_val($sformatf("zero_%0d", k), o_zero, vz[k]);
         check_val($sformatf("ovf_%0d", k), o_ovf, vo[k]);
         check_val($sformatf("p0_ovf_%0d", k), f0_ovf, vo[k]);
`endif
         step();
         check_val($sformatf("no_dup_%0d", k), o_valid, 1'b0);
      end

      // back-to-back with a 5-cycle downstream stall
      idx_in = 0; idx_out = 0;
      gk = '0; c0 = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         ready = !(cyc >= 2 && cyc < 7);
         valid = (idx_in < 4);
         pk    = 32'(idx_in + 1);
         #1;
         if (cyc == 2) check_val("stall_ready", o_ready, 1'b0);
         if (!ready) begin
            check_val($sformatf("stall_valid_%0d", cyc), o_valid, 1'b1);
            check_val($sformatf("stall_sum_%0d", cyc), o_sum, 32'h1);
         end
         if (o_valid && ready) begin
            check_val($sformatf("b2b_sum_%0d", idx_out), o_sum, 32'(idx_out + 1));
            check_val($sformatf("b2b_cycle_%0d", idx_out), cyc, 7 + idx_out);
            idx_out++;
         end
         if (valid && o_ready) idx_in++;
         step();
      end
      check_val("b2b_count", idx_out, 4);
      valid = 1'b0; ready = 1'b1;
      step();

      // flush with two results in flight; offered input in flush cycle is dropped
      ready = 1'b0; valid = 1'b1; pk = 32'h5;
      step();
      pk = 32'h6;
      step();
      check_val("fl_pre_valid", o_valid, 1'b1);
      flush = 1'b1; pk = 32'h7;
      step();
      flush = 1'b0; valid = 1'b0; ready = 1'b1;
      #1;
      check_val("fl_valid", o_valid, 1'b0);
      check_val("fl_ready", o_ready, 1'b1);
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         seen += int'(o_valid);
      end
      check_val("fl_no_result", seen, 0);

      // flush beats a simultaneous accept into an empty pipe
      flush = 1'b1; valid = 1'b1; pk = 32'h9;
      step();
      flush = 1'b0; valid = 1'b0;
      seen = 0; seen0 = 0;
      for (int c = 0; c < 3; c++) begin
         seen  += int'(o_valid);
         seen0 += int'(v0_valid);
         step();
      end
      check_val("flwin_none", seen, 0);
      check_val("flwin_none0", seen0, 0);

      // asynchronous reset mid-cycle with results in flight
      ready = 1'b0; valid = 1'b1; pk = 32'h5;
      step();
      pk = 32'h6;
      step();
      valid = 1'b0;
      check_val("mr_pre_valid", o_valid, 1'b1);
      check_val("mr_pre_sum", o_sum, 32'h5);
      #3 rst = 1'b1;
      #1;
      check_val("mr_valid", o_valid, 1'b0);
      check_val("mr_sum", o_sum, 32'h0);
      check_val("mr_cout", o_cout, 1'b0);
      check_val("mr_valid0", v0_valid, 1'b0);
      #3 rst = 1'b0;
      ready = 1'b1;
      seen = 0; seen0 = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         seen  += int'(o_valid);
         seen0 += int'(v0_valid);
      end
      check_val("mr_no_result", seen, 0);
      check_val("mr_no_result0", seen0, 0);
      check_val("mr_ready", o_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
